// File: rtl/sdram_write_ctrl.sv
// SDRAM burst-write sequencer: ACT, back-to-back WRITE bursts fed from a show-ahead
// FIFO, PRE. Yields to refresh at burst boundaries and resumes from the saved address.
module sdram_write_ctrl #(
    parameter int BURST_LEN = 4,
    parameter int COL_W     = 9,
    parameter int TRCD      = 2,
    parameter int TWR       = 2,
    parameter int TRP       = 2,
    parameter int DQ_W      = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_trig,
    input  logic [1:0]      wr_bank,
    input  logic [11:0]     wr_row,
    input  logic [7:0]      wr_num_bursts,
    input  logic            w_en,
    input  logic            ref_req,
    output logic            w_req,
    output logic            write_data_end,
    output logic            write_ref_break_end,
    output logic [17:0]     wr_cmd,
    output logic            fifo_rd_en,
    input  logic [DQ_W-1:0] fifo_rd_data,
    output logic [DQ_W-1:0] wr_dq,
    output logic            dq_oe
);

    localparam logic [3:0] OP_NOP   = 4'b0111;
    localparam logic [3:0] OP_ACT   = 4'b0011;
    localparam logic [3:0] OP_WRITE = 4'b0100;
    localparam logic [3:0] OP_PRE   = 4'b0010;
    localparam logic [17:0] CMD_NOP = {OP_NOP, 2'b00, 12'd0};

    // Wait states hold for (Txx - 1) cycles; the command state itself is the first cycle.
    localparam logic [7:0] TRCD_END = 8'((TRCD > 1) ? TRCD - 2 : 0);
    localparam logic [7:0] TWR_END  = 8'((TWR > 1) ? TWR - 2 : 0);
    localparam logic [7:0] TRP_END  = 8'((TRP > 0) ? TRP - 1 : 0);
    localparam logic [7:0] BL_END   = 8'(BURST_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ACT, S_TRCD_WAIT, S_WRITE, S_TWR_WAIT, S_PRE, S_TRP_WAIT
    } state_t;

    typedef enum logic [1:0] {
        STOP_DONE, STOP_BREAK, STOP_ROW
    } stop_t;

    state_t           state, state_nxt;
    stop_t            stop_kind, stop_nxt;
    logic [7:0]       cnt, cnt_nxt;
    logic [1:0]       bank;
    logic [11:0]      row;
    logic [COL_W-1:0] col;
    logic [7:0]       remain;

    logic             issue_wr;
    logic [COL_W-1:0] col_inc;
    logic [COL_W-1:0] col_now;
    logic [7:0]       rem_now;
    state_t           after_act;
    state_t           after_stop;

    assign col_inc    = col + COL_W'(BURST_LEN);
    // Values as they stand once this burst's WRITE has taken effect (matters when BURST_LEN=1).
    assign col_now    = (cnt == 8'd0) ? col_inc : col;
    assign rem_now    = (cnt == 8'd0) ? remain - 8'd1 : remain;
    assign after_act  = (TRCD > 1) ? S_TRCD_WAIT : S_WRITE;
    assign after_stop = (TWR > 1) ? S_TWR_WAIT : S_PRE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            stop_kind <= STOP_DONE;
            cnt       <= 8'd0;
        end else begin
            state     <= state_nxt;
            stop_kind <= stop_nxt;
            cnt       <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt           = state;
        stop_nxt            = stop_kind;
        cnt_nxt             = cnt + 8'd1;
        wr_cmd              = CMD_NOP;
        dq_oe               = 1'b0;
        issue_wr            = 1'b0;
        write_data_end      = 1'b0;
        write_ref_break_end = 1'b0;
        case (state)
            S_IDLE: begin
                cnt_nxt = 8'd0;
                if (w_en && w_req) state_nxt = S_ACT;
            end
            S_ACT: begin
                wr_cmd    = {OP_ACT, bank, row};
                cnt_nxt   = 8'd0;
                state_nxt = after_act;
            end
            S_TRCD_WAIT: begin
                if (cnt == TRCD_END) begin
                    cnt_nxt   = 8'd0;
                    state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                dq_oe = 1'b1;
                if (cnt == 8'd0) begin
                    issue_wr = 1'b1;
                    wr_cmd   = {OP_WRITE, bank, 12'(col)};
                end
                if (cnt == BL_END) begin
                    cnt_nxt = 8'd0;
                    if (rem_now == 8'd0) begin
                        stop_nxt  = STOP_DONE;
                        state_nxt = after_stop;
                    end else if (ref_req) begin
                        stop_nxt  = STOP_BREAK;
                        state_nxt = after_stop;
                    end else if (col_now == '0) begin
                        stop_nxt  = STOP_ROW;
                        state_nxt = after_stop;
                    end
                end
            end
            S_TWR_WAIT: begin
                if (cnt == TWR_END) begin
                    cnt_nxt   = 8'd0;
                    state_nxt = S_PRE;
                end
            end
            S_PRE: begin
                wr_cmd    = {OP_PRE, bank, 12'd0};
                cnt_nxt   = 8'd0;
                state_nxt = S_TRP_WAIT;
            end
            S_TRP_WAIT: begin
                if (cnt == TRP_END) begin
                    cnt_nxt = 8'd0;
                    if (stop_kind == STOP_DONE) begin
                        write_data_end = 1'b1;
                        state_nxt      = S_IDLE;
                    end else if (stop_kind == STOP_BREAK || ref_req) begin
                        write_ref_break_end = 1'b1;
                        state_nxt           = S_IDLE;
                    end else begin
                        // Row crossing: open the next row right as tRP expires.
                        wr_cmd    = {OP_ACT, bank, row};
                        state_nxt = after_act;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign fifo_rd_en = dq_oe;
    assign wr_dq      = dq_oe ? fifo_rd_data : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_req  <= 1'b0;
            bank   <= 2'd0;
            row    <= 12'd0;
            col    <= '0;
            remain <= 8'd0;
        end else begin
            if (issue_wr) begin
                col    <= col_inc;
                remain <= remain - 8'd1;
                // Row advances at the wrapping WRITE so a break at row end resumes on the new row.
                if (col_inc == '0) row <= row + 12'd1;
            end
            if (write_data_end) begin
                w_req <= 1'b0;
            end else if (wr_trig && !w_req && wr_num_bursts != 8'd0) begin
                w_req  <= 1'b1;
                bank   <= wr_bank;
                row    <= wr_row;
                col    <= '0;
                remain <= wr_num_bursts;
            end
        end
    end

endmodule

// File: tb/tb_sdram_write_ctrl.sv
// Directed bench for sdram_write_ctrl: per-cycle vector tables for whole jobs plus
// hand-written sequences for row crossing and asynchronous reset mid-burst.
module tb_sdram_write_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_trig;
    logic [1:0]  wr_bank;
    logic [11:0] wr_row;
    logic [7:0]  wr_num_bursts;
    logic        w_en;
    logic        ref_req;
    logic        w_req;
    logic        write_data_end;
    logic        write_ref_break_end;
    logic [17:0] wr_cmd;
    logic        fifo_rd_en;
    logic [15:0] fifo_rd_data;
    logic [15:0] wr_dq;
    logic        dq_oe;

    sdram_write_ctrl dut (
        .clk                 (clk),
        .rst                 (rst),
        .wr_trig             (wr_trig),
        .wr_bank             (wr_bank),
        .wr_row              (wr_row),
        .wr_num_bursts       (wr_num_bursts),
        .w_en                (w_en),
        .ref_req             (ref_req),
        .w_req               (w_req),
        .write_data_end      (write_data_end),
        .write_ref_break_end (write_ref_break_end),
        .wr_cmd              (wr_cmd),
        .fifo_rd_en          (fifo_rd_en),
        .fifo_rd_data        (fifo_rd_data),
        .wr_dq               (wr_dq),
        .dq_oe               (dq_oe)
    );

    always #5 clk = ~clk;

    localparam logic [17:0] NOP = {4'b0111, 2'b00, 12'd0};

    // {w_req, wr_cmd, dq_oe, fifo_rd_en, wr_dq, write_data_end, write_ref_break_end}
    logic [38:0] obs;
    assign obs = {w_req, wr_cmd, dq_oe, fifo_rd_en, wr_dq, write_data_end, write_ref_break_end};

    typedef struct {
        logic        trig;
        logic [1:0]  bank;
        logic [11:0] row;
        logic [7:0]  nb;
        logic        w_en;
        logic        rr;
        logic [15:0] fd;
        logic [38:0] exp;
    } vec_t;

    vec_t        vq[$];
    logic [1:0]  jb;
    logic [11:0] jr;
    int          checks = 0;
    int          failures = 0;

    function automatic logic [17:0] act(input int b, input int r);
        return {4'b0011, 2'(b), 12'(r)};
    endfunction
    function automatic logic [17:0] wrc(input int b, input int c);
        return {4'b0100, 2'(b), 12'(c)};
    endfunction
    function automatic logic [17:0] pre(input int b);
        return {4'b0010, 2'(b), 12'd0};
    endfunction

    task automatic chk(input string name, input logic [38:0] got, input logic [38:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic add(input bit trig, input int nb, input bit wen, input bit rr, input bit wreq,
                       input logic [17:0] cmd, input bit oe, input bit dend, input bit bend);
        vec_t v;
        v.trig = trig; v.bank = jb; v.row = jr; v.nb = 8'(nb);
        v.w_en = wen; v.rr = rr;
        v.fd   = 16'h5A00 + 16'(vq.size());
        v.exp  = {wreq, cmd, oe, oe, (oe ? v.fd : 16'h0000), dend, bend};
        vq.push_back(v);
    endtask

    task automatic run(input string tag);
        for (int i = 0; i < vq.size(); i++) begin
            @(posedge clk); #1;
            wr_trig = vq[i].trig; wr_bank = vq[i].bank; wr_row = vq[i].row;
            wr_num_bursts = vq[i].nb; w_en = vq[i].w_en; ref_req = vq[i].rr;
            fifo_rd_data = vq[i].fd;
            @(negedge clk);
            chk($sformatf("%s[%0d]", tag, i), obs, vq[i].exp);
        end
        vq.delete();
    endtask

    task automatic cyc(input bit trig, input int nb, input bit wen, input bit rr);
        @(posedge clk); #1;
        wr_trig = trig; wr_bank = jb; wr_row = jr; wr_num_bursts = 8'(nb);
        w_en = wen; ref_req = rr; fifo_rd_data = 16'hBEEF;
        @(negedge clk);
    endtask

    initial begin
        logic [17:0] cmd;
        int dends, bends, writes;
        rst = 1'b1; wr_trig = 0; wr_bank = 0; wr_row = 0; wr_num_bursts = 0;
        w_en = 0; ref_req = 0; fifo_rd_data = 16'h1234;
        #2;
        chk("reset_state", obs, {1'b0, NOP, 20'h0});
        #10 rst = 1'b0;

        // Single job: bank 1, row 5, 2 bursts. Vector 0 is the trigger, vector c+1 is cycle c.
        jb = 2'd1; jr = 12'd5;
        add(1, 2, 0, 0, 0, NOP, 0, 0, 0);
        for (int c = 0; c <= 15; c++) begin
            cmd = NOP;
            if (c == 1)  cmd = act(1, 5);
            if (c == 3)  cmd = wrc(1, 0);
            if (c == 7)  cmd = wrc(1, 4);
            if (c == 12) cmd = pre(1);
            add(0, 0, c == 0, 0, c < 15, cmd, c >= 3 && c <= 10, c == 14, 0);
        end
        run("single");

        // Refresh break after the first of 4 bursts, resume at column 4.
        jb = 2'd2; jr = 12'd100;
        add(1, 4, 0, 0, 0, NOP, 0, 0, 0);
        for (int c = 0; c <= 39; c++) begin
            cmd = NOP;
            if (c == 1 || c == 21) cmd = act(2, 100);
            if (c == 3)  cmd = wrc(2, 0);
            if (c == 8)  cmd = pre(2);
            if (c == 23) cmd = wrc(2, 4);
            if (c == 27) cmd = wrc(2, 8);
            if (c == 31) cmd = wrc(2, 12);
            if (c == 36) cmd = pre(2);
            add(0, 0, c == 0 || c == 20, c >= 4 && c <= 12, c < 39, cmd,
                (c >= 3 && c <= 6) || (c >= 23 && c <= 34), c == 38, c == 10);
        end
        run("refresh");

        // Ignored inputs: zero-count trigger, w_en with no job, trigger during a pending job.
        jb = 2'd0; jr = 12'd9;
        add(1, 0, 0, 0, 0, NOP, 0, 0, 0);
        add(0, 0, 1, 0, 0, NOP, 0, 0, 0);
        add(0, 0, 0, 0, 0, NOP, 0, 0, 0);
        add(1, 1, 0, 0, 0, NOP, 0, 0, 0);
        jb = 2'd3; jr = 12'd44;
        add(1, 5, 0, 0, 1, NOP, 0, 0, 0);
        for (int c = 0; c <= 11; c++) begin
            cmd = NOP;
            if (c == 1) cmd = act(0, 9);
            if (c == 3) cmd = wrc(0, 0);
            if (c == 8) cmd = pre(0);
            add(0, 0, c == 0, 0, c < 11, cmd, c >= 3 && c <= 6, c == 10, 0);
        end
        run("ignored");

        // Row crossing: row 7, 130 bursts -> 128 on row 7, 2 on row 8.
        jb = 2'd3; jr = 12'd7;
        cyc(1, 130, 0, 0);
        cyc(0, 0, 1, 0);
        dends = 0; bends = 0; writes = 0;
        for (int c = 1; c <= 532; c++) begin
            cyc(0, 0, 0, 0);
            if (write_data_end) dends++;
            if (write_ref_break_end) bends++;
            if (wr_cmd[17:14] == 4'b0100) writes++;
            if (c == 1)   chk("row_act7", 39'(wr_cmd), 39'(act(3, 7)));
            if (c == 511) chk("row_wr508", 39'(wr_cmd), 39'(wrc(3, 508)));
            if (c == 514) chk("row_lastbeat_nop", 39'({dq_oe, wr_cmd}), 39'({1'b1, NOP}));
            if (c == 516) chk("row_pre", 39'(wr_cmd), 39'(pre(3)));
            if (c == 518) chk("row_act8", 39'(wr_cmd), 39'(act(3, 8)));
            if (c == 520) chk("row_wr0", 39'(wr_cmd), 39'(wrc(3, 0)));
            if (c == 524) chk("row_wr4", 39'(wr_cmd), 39'(wrc(3, 4)));
            if (c == 529) chk("row_pre_end", 39'(wr_cmd), 39'(pre(3)));
            if (c == 531) chk("row_dend", 39'(write_data_end), 39'd1);
            if (c == 532) chk("row_wreq_low", 39'(w_req), 39'd0);
        end
        chk("row_dend_count", 39'(dends), 39'd1);
        chk("row_bend_count", 39'(bends), 39'd0);
        chk("row_write_count", 39'(writes), 39'd130);

        // Asynchronous reset in the middle of the first burst.
        jb = 2'd1; jr = 12'd5;
        cyc(1, 2, 0, 0);
        cyc(0, 0, 1, 0);
        for (int c = 1; c <= 4; c++) cyc(0, 0, 0, 0);
        @(posedge clk); #2;
        chk("rst_mid_oe", 39'(dq_oe), 39'd1);
        rst = 1'b1; #1;
        chk("rst_async", obs, {1'b0, NOP, 20'h0});
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cyc(0, 0, 1, 0);
            chk($sformatf("rst_idle[%0d]", i), 39'({w_req, wr_cmd}), 39'({1'b0, NOP}));
        end
        cyc(1, 1, 0, 0);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 0);
        chk("rst_new_act", 39'(wr_cmd), 39'(act(1, 5)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
